// File: rtl/frame_sync_detector.sv
`default_nettype none
// ============================================================================
// Module   : frame_sync_detector
// Brief    : Hunt/confirm/locked frame aligner with flywheel; forwards payload.
// Revision : 1.0 - initial release
// ============================================================================
module frame_sync_detector #(
    parameter int               WIDTH       = 5,
    parameter logic [WIDTH-1:0] SYNC_WORD   = 5'b10110,
    parameter int               PAYLOAD_LEN = 4,
    parameter int               LOCK_COUNT  = 2,
    parameter int               MISS_LIMIT  = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             word_valid,
    input  logic [WIDTH-1:0] word_in,
    output logic             payload_valid,
    output logic [WIDTH-1:0] payload_data,
    output logic             payload_last,
    output logic             locked,
    output logic             sync_err,
    output logic [7:0]       frame_count
);

    localparam int CNT_W  = $clog2(PAYLOAD_LEN + 1);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(MISS_LIMIT + 1);

    localparam logic [CNT_W-1:0]  c_SYNC_SLOT = CNT_W'(PAYLOAD_LEN);
    localparam logic [CNT_W-1:0]  c_LAST_PAY  = CNT_W'(PAYLOAD_LEN - 1);
    localparam logic [GOOD_W-1:0] c_GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [MISS_W-1:0] c_MISS_LAST = MISS_W'(MISS_LIMIT - 1);

    typedef enum logic [1:0] {
        S_HUNT    = 2'd0,
        S_CONFIRM = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_word_cnt;
    logic [GOOD_W-1:0]  r_good_cnt;
    logic [MISS_W-1:0]  r_miss_cnt;

    logic w_is_sync;
    logic w_sync_slot;

    assign w_is_sync   = (word_in == SYNC_WORD);
    assign w_sync_slot = (r_word_cnt == c_SYNC_SLOT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_HUNT;
            r_word_cnt    <= '0;
            r_good_cnt    <= '0;
            r_miss_cnt    <= '0;
            payload_valid <= 1'b0;
            payload_data  <= '0;
            payload_last  <= 1'b0;
            locked        <= 1'b0;
            sync_err      <= 1'b0;
            frame_count   <= 8'd0;
        end else begin
            payload_valid <= 1'b0;
            payload_last  <= 1'b0;
            sync_err      <= 1'b0;
            if (word_valid) begin
                case (r_state)
                    S_HUNT: begin
                        if (w_is_sync) begin
                            r_good_cnt <= GOOD_W'(1);
                            r_word_cnt <= '0;
                            r_miss_cnt <= '0;
                            if (LOCK_COUNT == 1) begin
                                r_state <= S_LOCKED;
                                locked  <= 1'b1;
                            end else begin
                                r_state <= S_CONFIRM;
                            end
                        end
                    end
                    S_CONFIRM: begin
                        if (!w_sync_slot) begin
                            r_word_cnt <= r_word_cnt + CNT_W'(1);
                        end else begin
                            r_word_cnt <= '0;
                            if (w_is_sync) begin
                                r_good_cnt <= r_good_cnt + GOOD_W'(1);
                                if (r_good_cnt == c_GOOD_LAST) begin
                                    r_state    <= S_LOCKED;
                                    locked     <= 1'b1;
                                    r_miss_cnt <= '0;
                                end
                            end else begin
                                // The failing word is consumed, not re-tried as a new sync.
                                r_state    <= S_HUNT;
                                r_good_cnt <= '0;
                            end
                        end
                    end
                    S_LOCKED: begin
                        if (!w_sync_slot) begin
                            r_word_cnt    <= r_word_cnt + CNT_W'(1);
                            payload_valid <= 1'b1;
                            payload_data  <= word_in;
                            payload_last  <= (r_word_cnt == c_LAST_PAY);
                        end else begin
                            r_word_cnt <= '0;
                            if (w_is_sync) begin
                                r_miss_cnt  <= '0;
                                frame_count <= frame_count + 8'd1;
                            end else begin
                                sync_err <= 1'b1;
                                if (r_miss_cnt == c_MISS_LAST) begin
                                    r_state    <= S_HUNT;
                                    locked     <= 1'b0;
                                    r_good_cnt <= '0;
                                    r_miss_cnt <= '0;
                                end else begin
                                    r_miss_cnt <= r_miss_cnt + MISS_W'(1);
                                end
                            end
                        end
                    end
                    default: r_state <= S_HUNT;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
